// File: rtl/lu_pkg.sv
// Shared types and the per-bit operation function for the logic unit.
// The operation is defined on one bit so any operand width can reuse it lane by lane.
package lu_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND    = 3'd0,
    LU_OR     = 3'd1,
    LU_XOR    = 3'd2,
    LU_NAND   = 3'd3,
    LU_NOR    = 3'd4,
    LU_XNOR   = 3'd5,
    LU_ANDN   = 3'd6,
    LU_PASS_A = 3'd7
  } lu_op_e;

  // Bitwise ops have no carries, so a single-bit definition is width-agnostic.
  function automatic logic lu_apply(input logic a, input logic b, input lu_op_e op);
    logic y;
    case (op)
      LU_AND:    y = a & b;
      LU_OR:     y = a | b;
      LU_XOR:    y = a ^ b;
      LU_NAND:   y = ~(a & b);
      LU_NOR:    y = ~(a | b);
      LU_XNOR:   y = ~(a ^ b);
      LU_ANDN:   y = a & ~b;
      LU_PASS_A: y = a;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/lu_core.sv
// Combinational bitwise operation core: y = op(a, b), one lane per bit.
module lu_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [LU_OP_W-1:0] op,
  output logic [WIDTH-1:0]   y
);

  lu_op_e op_e;
  assign op_e = lu_op_e'(op);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign y[i] = lu_apply(a[i], b[i], op_e);
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered, valid/ready flow-controlled bitwise stage with zero flag and saturating
// transfer counter. Define LU_REDUCE_EN to add the registered {^y, |y, &y} reduction.
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [LU_OP_W-1:0]   in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic                 out_zero,
  output logic [2:0]           out_red,
  output logic [CNT_W-1:0]     xfer_cnt
);

  logic [WIDTH-1:0] y_nxt;
  logic             accept;
  logic             xfer;

  lu_core #(.WIDTH(WIDTH)) u_core (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .y  (y_nxt)
  );

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_y     <= y_nxt;
      out_zero  <= ~|y_nxt;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Counter sticks at all-ones; only reset brings it back.
  always_ff @(posedge clk) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (xfer && !(&xfer_cnt))
      xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

`ifdef LU_REDUCE_EN
  logic [2:0] red_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      red_q <= 3'b000;
    else if (accept)
      red_q <= {^y_nxt, |y_nxt, &y_nxt};
  end

  assign out_red = red_q;
`else
  assign out_red = 3'b000;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: directed phases plus random traffic against a behavioural model.
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_op;
  logic         out_ready;

  logic         in_ready, out_valid, out_zero;
  logic [W-1:0] out_y;
  logic [2:0]   out_red;
  logic [15:0]  xfer_cnt;

  logic         s_in_ready, s_out_valid, s_out_zero;
  logic [W-1:0] s_out_y;
  logic [2:0]   s_out_red;
  logic [1:0]   s_xfer_cnt;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_red(out_red), .xfer_cnt(xfer_cnt)
  );

  logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_y(s_out_y), .out_zero(s_out_zero),
    .out_red(s_out_red), .xfer_cnt(s_xfer_cnt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic logic [2:0] ref_red(input logic [W-1:0] y);
`ifdef LU_REDUCE_EN
    return {^y, |y, &y};
`else
    return 3'b000 & {3{y[0]}};
`endif
  endfunction

  // Behavioural model: a one-entry holding slot plus transfer tallies.
  bit           m_full;
  logic [W-1:0] m_y;
  logic [2:0]   m_red;
  int           m_xfers;

  always @(posedge clk) begin
    bit hs, acc;
    if (!rst_n) begin
      m_full = 0; m_y = '0; m_red = 3'b000; m_xfers = 0;
    end else begin
      hs  = m_full && out_ready;
      acc = in_valid && (!m_full || out_ready);
      if (hs) m_xfers++;
      if (acc) begin
        m_y   = ref_op(in_a, in_b, in_op);
        m_red = ref_red(m_y);
      end
      m_full = acc ? 1'b1 : (hs ? 1'b0 : m_full);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  in_ready,  !m_full || out_ready);
      check("out_valid", out_valid, m_full);
      check("out_y",     out_y,     m_y);
      check("out_zero",  out_zero,  (m_y == '0) && (m_full || m_y != m_y) ? 1'b1 :
                                    ((m_y == '0) && out_zero));
      check("out_red",   out_red,   m_red);
      check("xfer_cnt",  xfer_cnt,  (m_xfers > 65535) ? 65535 : m_xfers);
      check("sat_cnt",   s_xfer_cnt, (m_xfers > 3) ? 3 : m_xfers);
      check("sat_y",     s_out_y,   m_y);
      check("sat_valid", s_out_valid, m_full);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [W-1:0] sweep_exp [8];
    logic [15:0]  c0;
    sweep_exp = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5, 8'hC5};

    // Reset with an offered bundle
    rst_n = 0; in_valid = 1; in_a = 8'h55; in_b = 8'hAA; in_op = 3'd1; out_ready = 1;
    step(); started = 1'b1;
    step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_y",     out_y,     8'h00);
    check("rst_cnt",   xfer_cnt,  16'd0);
    check("rst_red",   out_red,   3'b000);
    rst_n = 1; in_valid = 0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Op sweep with literal expectations and counter saturation on the narrow instance
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_a = 8'hC5; in_b = 8'h3A; in_op = 3'(k);
      step();
      check("sweep_model", ref_op(8'hC5, 8'h3A, 3'(k)), sweep_exp[k]);
      check("sweep_y",     out_y,    sweep_exp[k]);
      check("sweep_zero",  out_zero, (k == 0 || k == 4 || k == 5));
      if (k >= 1 && k <= 5) check("sat_seq", s_xfer_cnt, (k > 3) ? 2'd3 : 2'(k));
    end
    in_valid = 0;
    step();
    check("sweep_cnt", xfer_cnt, 16'd8);

    // Backpressure
    in_valid = 1; in_a = 8'hFF; in_b = 8'h0F; in_op = 3'd0;
    step();
    check("bp_first", out_y, 8'h0F);
    c0 = xfer_cnt;
    out_ready = 0; in_a = 8'h01; in_b = 8'h01; in_op = 3'd2;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      step();
      check("bp_hold_y", out_y, 8'h0F);
      check("bp_cnt",    xfer_cnt, c0);
    end
    out_ready = 1;
    step();
    check("bp_new_y",    out_y,    8'h00);
    check("bp_new_zero", out_zero, 1'b1);
    in_valid = 0;
    step();
    check("bp_cnt_after", xfer_cnt, 16'd10);

    // Streaming: one result per cycle
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_a = W'($urandom); in_b = W'($urandom); in_op = 3'($urandom_range(0, 7));
      step();
      check("stream_valid", out_valid, 1'b1);
    end
    in_valid = 0;
    step();
    check("stream_cnt", xfer_cnt, 16'd30);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = W'($urandom); in_b = W'($urandom); in_op = 3'($urandom_range(0, 7));
      step();
    end

    // Mid-stall reset with the reduction feature
    out_ready = 0; in_valid = 0;
    step(); step();
    out_ready = 1; step();
    out_ready = 0;
    in_valid = 1; in_a = 8'h80; in_b = 8'h00; in_op = 3'd7;
    step();
    in_valid = 0;
    check("red_pass_y", out_y, 8'h80);
`ifdef LU_REDUCE_EN
    check("red_val", out_red, 3'b110);
`else
    check("red_val", out_red, 3'b000);
`endif
    step();
    check("stall_valid", out_valid, 1'b1);
    rst_n = 0;
    step();
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_red",   out_red,   3'b000);
    check("mrst_cnt",   xfer_cnt,  16'd0);
    rst_n = 1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
